elink_rx_deframer: RTL

- Protocol-side consumer of the eLink parallel stream: the far-end counterpart of the link transmitter's 72-bit deserialised word format (8 data bytes plus 8 frame bits per clock).
- Reassembles framed 16-byte packets into emesh transactions, buffers them in a small FIFO, and back-pressures the link through wr/rd wait.
- Used as the chip-side link model and as the FPGA loopback checker, clocked by the divided link clock.

---
 rtl/elink_rx_deframer_if.sv | 24 ++
 rtl/elink_rx_deframer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/elink_rx_deframer_if.sv
// emesh-side bus of the eLink receive deframer: transaction outputs plus head-of-line wait inputs.
interface elink_rx_deframer_if;
  logic        emesh_access_inb;
  logic        emesh_write_inb;
  logic [1:0]  emesh_datamode_inb;
  logic [3:0]  emesh_ctrlmode_inb;
  logic [31:0] emesh_dstaddr_inb;
  logic [31:0] emesh_srcaddr_inb;
  logic [31:0] emesh_data_inb;
  logic        emesh_wr_wait_outb;
  logic        emesh_rd_wait_outb;

  modport master (
    output emesh_access_inb, emesh_write_inb, emesh_datamode_inb, emesh_ctrlmode_inb,
           emesh_dstaddr_inb, emesh_srcaddr_inb, emesh_data_inb,
    input  emesh_wr_wait_outb, emesh_rd_wait_outb
  );

  modport slave (
    input  emesh_access_inb, emesh_write_inb, emesh_datamode_inb, emesh_ctrlmode_inb,
           emesh_dstaddr_inb, emesh_srcaddr_inb, emesh_data_inb,
    output emesh_wr_wait_outb, emesh_rd_wait_outb
  );
endinterface

// File: rtl/elink_rx_deframer.sv
// eLink receive deframer: two framed 64-bit words -> one emesh transaction via an in-order FIFO.
// Optional ELINK_RX_ERRCNT_EN adds the saturating err_count output.
module elink_rx_deframer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_MARGIN = 3
) (
  input  logic                rxi_lclk,
  input  logic                reset_n,
  input  logic [63:0]         rxi_data,
  input  logic [7:0]          rxi_frame,
  output logic                rxo_wr_wait,
  output logic                rxo_rd_wait,
`ifdef ELINK_RX_ERRCNT_EN
  output logic [7:0]          err_count,
`endif
  elink_rx_deframer_if.master emesh
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 103;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WORD_A = 2'd1,
    PKT_WR = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     word_a_q;
  logic            frm_ff_s, frm_00_s;
  logic            capture_a_s, capture_b_s, frame_err_s;
  logic [EW-1:0]   pkt_s;
  logic            push_req_s, push_s, drop_s, pop_s, stall_s, full_s, empty_s;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   out_q;
  logic            out_valid_q;
  logic            wait_q;
  logic            unused_bits_s;

  assign frm_ff_s = (rxi_frame == 8'hFF);
  assign frm_00_s = (rxi_frame == 8'h00);

  always_ff @(posedge rxi_lclk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE and PKT_WR both accept a new word A, which is what makes bursts gapless
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (frm_ff_s) state_d = WORD_A; else state_d = IDLE;
      WORD_A:  if (frm_ff_s) state_d = PKT_WR; else state_d = IDLE;
      PKT_WR:  if (frm_ff_s) state_d = WORD_A; else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_a_s = 1'b0;
    capture_b_s = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      IDLE, PKT_WR: begin
        capture_a_s = frm_ff_s;
        frame_err_s = !frm_ff_s && !frm_00_s;
      end
      WORD_A: begin
        capture_b_s = frm_ff_s;
        frame_err_s = !frm_ff_s;
      end
      default: begin
        frame_err_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rxi_lclk) begin
    if (!reset_n) begin
      word_a_q <= 64'h0;
    end else if (capture_a_s) begin
      word_a_q <= rxi_data;
    end
  end

  // entry = {ctrlmode, datamode, write, dstaddr, srcaddr, data}; access bit gates the push
  assign pkt_s = {word_a_q[63:57], word_a_q[55:24], rxi_data[55:24],
                  word_a_q[23:0], rxi_data[63:56]};

  assign push_req_s = capture_b_s && word_a_q[56];
  assign full_s     = (count_q == CW'(FIFO_DEPTH));
  assign empty_s    = (count_q == {CW{1'b0}});
  assign push_s     = push_req_s && !full_s;
  assign drop_s     = push_req_s && full_s;
  assign stall_s    = out_valid_q && (out_q[96] ? emesh.emesh_wr_wait_outb
                                                : emesh.emesh_rd_wait_outb);
  assign pop_s      = !empty_s && !stall_s;

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge rxi_lclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= pkt_s;
    end
  end

  always_ff @(posedge rxi_lclk) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      wait_q   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      wait_q  <= ((CW'(FIFO_DEPTH) - count_d) <= CW'(WAIT_MARGIN));
    end
  end

  // output register holds while stalled and clears once its entry is taken
  always_ff @(posedge rxi_lclk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= {EW{1'b0}};
    end else if (pop_s) begin
      out_valid_q <= 1'b1;
      out_q       <= mem_q[rd_ptr_q];
    end else if (!stall_s) begin
      out_valid_q <= 1'b0;
      out_q       <= {EW{1'b0}};
    end
  end

  assign rxo_wr_wait              = wait_q;
  assign rxo_rd_wait              = wait_q;
  assign emesh.emesh_access_inb   = out_valid_q;
  assign emesh.emesh_ctrlmode_inb = out_q[102:99];
  assign emesh.emesh_datamode_inb = out_q[98:97];
  assign emesh.emesh_write_inb    = out_q[96];
  assign emesh.emesh_dstaddr_inb  = out_q[95:64];
  assign emesh.emesh_srcaddr_inb  = out_q[63:32];
  assign emesh.emesh_data_inb     = out_q[31:0];

`ifdef ELINK_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge rxi_lclk) begin
    if (!reset_n) begin
      err_cnt_q <= 8'h00;
    end else if ((frame_err_s || drop_s) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_count     = err_cnt_q;
  assign unused_bits_s = ^rxi_data[23:0];
`else
  assign unused_bits_s = ^{rxi_data[23:0], frame_err_s, drop_s};
`endif

endmodule
